// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with load, logical
// shifts, rotates and optional arithmetic right shift (USR_ARITH_EN).
// Multi-step shifts run one position per cycle with busy/done handshake.
// Ports: clk, rst (sync, active-low), start, mode[2:0], amt[AW-1:0],
//   d[WIDTH-1:0], sin_r, sin_l -> q[WIDTH-1:0], sout_r, sout_l, busy, done.
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SRL  = 3'b010;
    localparam logic [2:0] M_SLL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t          state;
    logic [2:0]      mode_r;
    logic [AW-1:0]   cnt;
    logic [WIDTH-1:0] nxt_q;
    logic            arith_en;
    logic            cmd_shift;

`ifdef USR_ARITH_EN
    assign arith_en = 1'b1;
`else
    assign arith_en = 1'b0;
`endif

    // Modes that need stepping; ASR counts only when the feature is built in.
    assign cmd_shift = (mode == M_SRL) || (mode == M_SLL) ||
                       (mode == M_ROR) || (mode == M_ROL) ||
                       (arith_en && (mode == M_ASR));

    // One-position step on the current q using the latched mode.
    always_comb begin
        nxt_q = q;
        unique case (1'b1)
            (mode_r == M_SRL): nxt_q = {sin_r, q[WIDTH-1:1]};
            (mode_r == M_SLL): nxt_q = {q[WIDTH-2:0], sin_l};
            (mode_r == M_ROR): nxt_q = {q[0], q[WIDTH-1:1]};
            (mode_r == M_ROL): nxt_q = {q[WIDTH-2:0], q[WIDTH-1]};
            (arith_en && (mode_r == M_ASR)):
                nxt_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default: nxt_q = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            q      <= '0;
            cnt    <= '0;
            mode_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mode_r <= mode;
                        busy   <= 1'b1;
                        if (mode == M_LOAD) begin
                            q     <= d;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else if (cmd_shift && (amt != '0)) begin
                            cnt   <= amt;
                            state <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    q   <= nxt_q;
                    cnt <= cnt - AW'(1);
                    if (cnt == AW'(1)) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed scoreboard bench for univ_shift_reg (WIDTH=8).
// Expected q values are queued at stimulus time and popped at done.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] sb[$];

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
        .d(d), .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to done; checks q at done,
    // busy occupancy and the return to idle.
    task automatic run(input string tag, input logic [2:0] m,
                       input logic [AW-1:0] a, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input int eb,
                       input bit hold);
        int nb;
        int nd;
        bit got;
        logic [W-1:0] e;
        sb.push_back(eq);
        start = 1'b1; mode = m; amt = a; d = dv;
        step();
        if (hold) begin
            mode = 3'b001; d = '0; amt = '0;
        end else begin
            start = 1'b0;
        end
        nb = 0; nd = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
                start = 1'b0;
                e = sb.pop_front();
                chk({tag, "_q"}, 32'(q), 32'(e));
            end else begin
                step();
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(eb));
        step();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold_q"}, 32'(q), 32'(eq));
    endtask

    initial begin
        int nd;
        rst = 1'b0; start = 1'b0; mode = '0; amt = '0; d = '0;
        sin_r = 1'b0; sin_l = 1'b0;
        step();
        step();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_sout", {30'd0, sout_l, sout_r}, 32'd0);
        rst = 1'b1;
        step();

        run("load", 3'b001, 4'd0, 8'hA5, 8'hA5, 1, 1'b0);
        chk("load_sout", {30'd0, sout_l, sout_r}, 32'd3);

        // SRL A5 by 3: per-edge values through the scoreboard.
        sb.push_back(8'h52); sb.push_back(8'h29); sb.push_back(8'h14);
        start = 1'b1; mode = 3'b010; amt = 4'd3; sin_r = 1'b0;
        step();
        start = 1'b0;
        chk("srl_k_q", 32'(q), 32'hA5);
        chk("srl_k_busy", {30'd0, busy, done}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("srl_step_q", 32'(q), 32'(sb.pop_front()));
            chk("srl_step_bd", {30'd0, busy, done},
                (i == 2) ? 32'd3 : 32'd2);
        end
        step();
        chk("srl_idle", {30'd0, busy, done}, 32'd0);

        run("load00", 3'b001, 4'd0, 8'h00, 8'h00, 1, 1'b0);
        sin_l = 1'b1;
        run("sll2", 3'b011, 4'd2, 8'h00, 8'h03, 3, 1'b0);
        sin_l = 1'b0;

        run("ldA5", 3'b001, 4'd0, 8'hA5, 8'hA5, 1, 1'b0);
        run("rol4", 3'b101, 4'd4, 8'h00, 8'h5A, 5, 1'b0);
        run("ld81", 3'b001, 4'd0, 8'h81, 8'h81, 1, 1'b0);
        run("ror9", 3'b100, 4'd9, 8'h00, 8'hC0, 10, 1'b0);
        run("ld3C", 3'b001, 4'd0, 8'h3C, 8'h3C, 1, 1'b0);
        run("sll0", 3'b011, 4'd0, 8'h00, 8'h3C, 1, 1'b0);
        run("nop7", 3'b111, 4'd5, 8'hFF, 8'h3C, 1, 1'b0);

        run("ld90", 3'b001, 4'd0, 8'h90, 8'h90, 1, 1'b0);
`ifdef USR_ARITH_EN
        run("asr2", 3'b110, 4'd2, 8'h00, 8'hE4, 3, 1'b0);
`else
        run("asr2_off", 3'b110, 4'd2, 8'h00, 8'h90, 1, 1'b0);
`endif

        // Load request held during a running shift must be ignored.
        run("ldFF", 3'b001, 4'd0, 8'hFF, 8'hFF, 1, 1'b0);
        sin_r = 1'b0;
        run("srl5_hold", 3'b010, 4'd5, 8'h00, 8'h07, 6, 1'b1);

        // Reset on the second RUN cycle aborts with no done.
        run("ldFF2", 3'b001, 4'd0, 8'hFF, 8'hFF, 1, 1'b0);
        start = 1'b1; mode = 3'b010; amt = 4'd5;
        step();
        start = 1'b0;
        step();
        chk("abort_mid_q", 32'(q), 32'h7F);
        rst = 1'b0;
        step();
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_bd", {30'd0, busy, done}, 32'd0);
        rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) nd++;
            step();
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        chk("abort_q_stay", 32'(q), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
